// File: rtl/sipo_frame_rx_if.sv
// Bundle of serial-line, consumer-handshake and status signals for sipo_frame_rx.
// The master modport is the line/consumer side; the slave modport is the receiver.
interface sipo_frame_rx_if #(
    parameter int WIDTH = 4
);
    logic             si;
    logic             si_en;
    logic             rd_en;
    logic             clr;
    logic [WIDTH-1:0] dout;
    logic             dvalid;
    logic             ovr;
    logic             ferr;
    logic             busy;

    modport master (
        output si, si_en, rd_en, clr,
        input  dout, dvalid, ovr, ferr, busy
    );

    modport slave (
        input  si, si_en, rd_en, clr,
        output dout, dvalid, ovr, ferr, busy
    );
endinterface

// File: rtl/sipo_frame_rx.sv
// Serial-to-parallel frame receiver: start bit 0, WIDTH data bits LSB-first, stop bit 1,
// delivered through a one-entry holding register with sticky overrun/framing flags.
module sipo_frame_rx #(
    parameter int WIDTH = 4
) (
    input logic          CK,
    input logic          RSTn,
    sipo_frame_rx_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DATA  = 2'd1;
    localparam logic [1:0] S_STOP  = 2'd2;
    localparam logic [1:0] S_BREAK = 2'd3;

    logic [1:0]       state_q,  state_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH-1:0] shreg_q,  shreg_d;
    logic [WIDTH-1:0] dout_q,   dout_d;
    logic             dvalid_q, dvalid_d;
    logic             ovr_q,    ovr_d;
    logic             ferr_q,   ferr_d;

    logic good_stop;
    logic bad_stop;
    logic ovr_set;

    assign good_stop = bus.si_en && (state_q == S_STOP) &&  bus.si;
    assign bad_stop  = bus.si_en && (state_q == S_STOP) && !bus.si;

    // Frame sequencing: only strobed edges advance the line-side state.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        if (bus.si_en) begin
            case (state_q)
                S_IDLE: begin
                    if (!bus.si) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                    end
                end
                S_DATA: begin
                    shreg_d = {bus.si, shreg_q[WIDTH-1:1]};
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) state_d = S_STOP;
                end
                S_STOP:  state_d = bus.si ? S_IDLE : S_BREAK;
                default: if (bus.si) state_d = S_IDLE;
            endcase
        end
    end

    // Holding register: a same-edge pop frees the slot for the arriving word.
    always_comb begin
        dout_d   = dout_q;
        dvalid_d = dvalid_q;
        ovr_set  = 1'b0;
        if (good_stop) begin
            if (!dvalid_q || bus.rd_en) begin
                dout_d   = shreg_q;
                dvalid_d = 1'b1;
            end else begin
                ovr_set  = 1'b1;
            end
        end else if (bus.rd_en) begin
            dvalid_d = 1'b0;
        end
    end

    // Sticky flags: a set condition beats clr on the same edge.
    always_comb begin
        ovr_d  = ovr_q;
        ferr_d = ferr_q;
        if (bus.clr) begin
            ovr_d  = 1'b0;
            ferr_d = 1'b0;
        end
        if (ovr_set)  ovr_d  = 1'b1;
        if (bad_stop) ferr_d = 1'b1;
    end

    always_ff @(posedge CK or negedge RSTn) begin
        if (!RSTn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            shreg_q  <= '0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
            ovr_q    <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values of the others.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            ovr_q    <= ovr_d;
            ferr_q   <= ferr_d;
        end
    end

    assign bus.dout   = dout_q;
    assign bus.dvalid = dvalid_q;
    assign bus.ovr    = ovr_q;
    assign bus.ferr   = ferr_q;
    assign bus.busy   = (state_q != S_IDLE);
endmodule

// File: tb/tb_sipo_frame_rx.sv
// Directed bench for sipo_frame_rx: stimulus pushes expected output snapshots into a
// queue, and a negedge monitor pops and compares them against the DUT.
module tb_sipo_frame_rx;
    logic CK;
    logic RSTn;

    sipo_frame_rx_if #(.WIDTH(4)) bus ();

    sipo_frame_rx #(.WIDTH(4)) dut (
        .CK   (CK),
        .RSTn (RSTn),
        .bus  (bus)
    );

    typedef struct packed {
        logic [3:0] dout;
        logic       dvalid;
        logic       ovr;
        logic       ferr;
        logic       busy;
    } snap_t;

    snap_t exp_q[$];
    string name_q[$];
    int    tests  = 0;
    int    failed = 0;

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic check(input string name, input snap_t act, input snap_t exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got dout=%h dvalid=%b ovr=%b ferr=%b busy=%b, expected dout=%h dvalid=%b ovr=%b ferr=%b busy=%b",
                     name, act.dout, act.dvalid, act.ovr, act.ferr, act.busy,
                     exp.dout, exp.dvalid, exp.ovr, exp.ferr, exp.busy);
        end
    endtask

    // Monitor: compares the oldest pending expectation on each falling edge.
    always @(negedge CK) begin
        if (exp_q.size() > 0) begin
            snap_t e;
            snap_t a;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = '{dout: bus.dout, dvalid: bus.dvalid, ovr: bus.ovr, ferr: bus.ferr, busy: bus.busy};
            check(n, a, e);
        end
    end

    task automatic expect_out(input string name, input logic [3:0] d, input logic v,
                              input logic o, input logic f, input logic b);
        exp_q.push_back('{dout: d, dvalid: v, ovr: o, ferr: f, busy: b});
        name_q.push_back(name);
    endtask

    // One clock edge with the given line/handshake inputs; strobe and pulses drop afterwards.
    task automatic tick(input logic s, input logic en, input logic rd, input logic c);
        @(negedge CK);
        bus.si    = s;
        bus.si_en = en;
        bus.rd_en = rd;
        bus.clr   = c;
        @(posedge CK);
        #1;
        bus.si_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.clr   = 1'b0;
    endtask

    task automatic send(input logic [3:0] w, input logic stop, input logic rd_on_stop,
                        input logic clr_on_stop);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick(w[i], 1'b1, 1'b0, 1'b0);
        tick(stop, 1'b1, rd_on_stop, clr_on_stop);
    endtask

    task automatic slow_bit(input logic s);
        tick(s, 1'b1, 1'b0, 1'b0);
        repeat (2) @(posedge CK);
        #1;
    endtask

    initial begin
        RSTn      = 1'b0;
        bus.si    = 1'b1;
        bus.si_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.clr   = 1'b0;
        #1;
        expect_out("reset", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge CK);
        @(negedge CK);
        #2;
        RSTn = 1'b1;

        // Good frame 0xA into an empty holding register.
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        expect_out("start_busy", 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) tick(i[0], 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        expect_out("deliver_a", 4'hA, 1'b1, 1'b0, 1'b0, 1'b0);

        // Overrun: 0x3 arrives while 0xA is unread.
        send(4'h3, 1'b1, 1'b0, 1'b0);
        expect_out("overrun", 4'hA, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        expect_out("clr_ovr", 4'hA, 1'b1, 1'b0, 1'b0, 1'b0);

        // Same-edge pop and delivery, then a plain pop and an empty pop.
        send(4'h3, 1'b1, 1'b1, 1'b0);
        expect_out("pop_deliver", 4'h3, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        expect_out("pop", 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        expect_out("pop_empty", 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);

        // Framing error, BREAK ignores low line, recovery on high strobe.
        send(4'hF, 1'b0, 1'b0, 1'b0);
        expect_out("ferr", 4'h3, 1'b0, 1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        expect_out("break_hold", 4'h3, 1'b0, 1'b0, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        expect_out("break_exit", 4'h3, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        expect_out("restart", 4'h3, 1'b0, 1'b0, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        expect_out("deliver_9", 4'h9, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b1);
        expect_out("clr_ferr_pop", 4'h9, 1'b0, 1'b0, 1'b0, 1'b0);

        // Sparse strobes: one every third cycle, line held in between.
        slow_bit(1'b0);
        slow_bit(1'b1);
        expect_out("slow_mid", 4'h9, 1'b0, 1'b0, 1'b0, 1'b1);
        slow_bit(1'b0);
        slow_bit(1'b1);
        slow_bit(1'b0);
        slow_bit(1'b1);
        expect_out("slow_deliver_5", 4'h5, 1'b1, 1'b0, 1'b0, 1'b0);

        // Framing error on the same edge as clr: the set wins.
        send(4'h0, 1'b0, 1'b0, 1'b1);
        expect_out("ferr_beats_clr", 4'h5, 1'b1, 1'b0, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of DATA.
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        expect_out("pre_reset_busy", 4'h5, 1'b1, 1'b0, 1'b1, 1'b1);
        @(posedge CK);
        #1;
        RSTn = 1'b0;
        #1;
        expect_out("async_reset", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge CK);
        #2;
        RSTn = 1'b1;
        send(4'hC, 1'b1, 1'b0, 1'b0);
        expect_out("deliver_c", 4'hC, 1'b1, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CK);
        if (exp_q.size() > 0) begin
            failed++;
            $display("FAIL drain: %0d expectations still pending, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
